// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
//   mem_op_e    : operation code driven by the memory stage
//   lsu_state_e : LSU control state (idle / sub-word store write-back)
//   mem_size_e  : access size derived from the operation
//   is_store()  : true for SB/SH/SW
//   op_size()   : byte / halfword / word size of an operation
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WR   = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic mem_size_e op_size(input mem_op_e op);
        case (op)
            LB, LBU, SB: return SZ_B;
            LH, LHU, SH: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit (little-endian lanes).
//   op       : memory operation (selects size and sign/zero extension)
//   off      : byte offset addr[1:0]
//   rd_word  : word read from memory
//   sdata    : low 16 bits of the store value
//   load_ext : addressed lane of rd_word, extended to WIDTH
//   merged   : rd_word with the addressed byte/halfword replaced by sdata
module lsu_lane_align
    import mips_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  mem_op_e          op,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] rd_word,
    input  logic [15:0]      sdata,
    output logic [WIDTH-1:0] load_ext,
    output logic [WIDTH-1:0] merged
);

    logic [4:0]       sh;
    logic [WIDTH-1:0] shifted;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic             sext;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] ins;

    // Halfword accesses are only ever issued with off[0]=0, so one shift covers both sizes.
    assign sh      = {off, 3'b000};
    assign shifted = rd_word >> sh;
    assign lane_b  = shifted[7:0];
    assign lane_h  = shifted[15:0];
    assign sext    = (op == LB) || (op == LH);

    always_comb begin
        load_ext = rd_word;
        mask     = '0;
        ins      = '0;
        case (op_size(op))
            SZ_B: begin
                load_ext = {{(WIDTH-8){sext & lane_b[7]}}, lane_b};
                mask     = WIDTH'(8'hFF) << sh;
                ins      = WIDTH'(sdata[7:0]) << sh;
            end
            SZ_H: begin
                load_ext = {{(WIDTH-16){sext & lane_h[15]}}, lane_h};
                mask     = WIDTH'(16'hFFFF) << sh;
                ins      = WIDTH'(sdata) << sh;
            end
            default: begin
                load_ext = rd_word;
                mask     = '0;
                ins      = '0;
            end
        endcase
    end

    assign merged = (rd_word & ~mask) | (ins & mask);

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit in front of a word-addressed data memory without byte enables.
// Sub-word loads are extracted and extended from the read word; sub-word stores use a
// read-modify-write (read + stall, then write the merged word). Misaligned halfword/word
// accesses are dropped and flagged. Load results are registered toward writeback.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid, mem_op  : request strobe and operation
//   addr, store_data   : byte address and store value
//   stall              : pipeline must hold its inputs this cycle
//   load_data/valid    : registered extended load result and 1-cycle valid pulse
//   misalign           : 1-cycle pulse after a misaligned request
//   bounds_err         : (LSU_BOUNDS_CHECK_EN only) 1-cycle pulse after an out-of-range request
//   MemRead/MemWrite/Address/WD/RD : data memory interface, RD valid after negedge
// Optional build macro: LSU_BOUNDS_CHECK_EN enables the out-of-range fault check.
module mem_lsu
    import mips_mem_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTHI = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  mem_op_e          mem_op,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             stall,
    output logic [WIDTH-1:0] load_data,
    output logic             load_valid,
    output logic             misalign,
`ifdef LSU_BOUNDS_CHECK_EN
    output logic             bounds_err,
`endif
    output logic             MemRead,
    output logic             MemWrite,
    output logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] WD,
    input  logic [WIDTH-1:0] RD
);

    lsu_state_e        state_q, state_d;
    logic [WIDTH-1:0]  merge_q;
    // Only the bits the memory decodes are kept for the write-back cycle.
    logic [DEPTHI-1:0] addr_q;

    logic             misal;
    logic             oob;
    logic             idle_req;
    logic             access_ok;
    logic             do_load;
    logic             do_merge;
    logic [WIDTH-1:0] load_ext;
    logic [WIDTH-1:0] merged;

    always_comb begin
        case (op_size(mem_op))
            SZ_H:    misal = addr[0];
            SZ_W:    misal = |addr[1:0];
            default: misal = 1'b0;
        endcase
    end

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob = |addr[WIDTH-1:DEPTHI+2];
`else
    assign oob = 1'b0;
`endif

    assign idle_req  = (state_q == S_IDLE) && req_valid && !rst;
    assign access_ok = idle_req && !misal && !oob;
    assign do_load   = access_ok && !is_store(mem_op);
    assign do_merge  = access_ok && ((mem_op == SB) || (mem_op == SH));

    lsu_lane_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .op       (mem_op),
        .off      (addr[1:0]),
        .rd_word  (RD),
        .sdata    (store_data[15:0]),
        .load_ext (load_ext),
        .merged   (merged)
    );

    always_comb begin
        state_d  = state_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        stall    = 1'b0;
        Address  = {2'b00, addr[WIDTH-1:2]};
        WD       = store_data;
        case (state_q)
            S_IDLE: begin
                if (access_ok) begin
                    if (!is_store(mem_op)) begin
                        MemRead = 1'b1;
                    end else if (mem_op == SW) begin
                        MemWrite = 1'b1;
                    end else begin
                        // Sub-word store: read the word now, write the merge next cycle.
                        MemRead = 1'b1;
                        stall   = 1'b1;
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                MemWrite = 1'b1;
                WD       = merge_q;
                Address  = WIDTH'(addr_q);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            stall    = 1'b0;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            merge_q    <= '0;
            addr_q     <= '0;
`ifdef LSU_BOUNDS_CHECK_EN
            bounds_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            load_valid <= do_load;
            misalign   <= idle_req && misal;
`ifdef LSU_BOUNDS_CHECK_EN
            // Misalignment wins when both faults are present.
            bounds_err <= idle_req && oob && !misal;
`endif
            if (do_load) begin
                load_data <= load_ext;
            end
            if (do_merge) begin
                merge_q <= merged;
                addr_q  <= addr[DEPTHI+1:2];
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    mem_op_e     mem_op = LW;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
`ifdef LSU_BOUNDS_CHECK_EN
    logic        bounds_err;
`endif
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WD;
    logic [31:0] RD = '0;

    mem_lsu #(
        .WIDTH  (32),
        .DEPTHI (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .mem_op     (mem_op),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
`ifdef LSU_BOUNDS_CHECK_EN
        .bounds_err (bounds_err),
`endif
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .WD         (WD),
        .RD         (RD)
    );

    always #5 clk = ~clk;

    // Word-addressed data memory model without byte enables.
    logic [31:0] mem [0:65535];
    always @(negedge clk) if (MemRead) RD <= mem[Address[15:0]];
    always @(posedge clk) if (MemWrite) mem[Address[15:0]] <= WD;

    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] data;
    } wr_t;

    logic [31:0] exp_load [$];
    wr_t         exp_wr [$];
    int          exp_misal = 0;
    int          exp_bounds = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (MemRead && MemWrite) chk("strobe_overlap", 32'd1, 32'd0);
        if (load_valid) begin
            if (exp_load.size() == 0) chk("load_unexpected", load_data, 32'hxxxxxxxx);
            else chk("load_data", load_data, exp_load.pop_front());
        end
        if (MemWrite) begin
            if (exp_wr.size() == 0) begin
                chk("write_unexpected", WD, 32'hxxxxxxxx);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("write_addr", {16'h0, Address[15:0]}, {16'h0, e.idx});
                chk("write_data", WD, e.data);
            end
        end
        if (misalign) begin
            chk("misalign_expected", {31'h0, exp_misal > 0}, 32'd1);
            if (exp_misal > 0) exp_misal--;
        end
`ifdef LSU_BOUNDS_CHECK_EN
        if (bounds_err) begin
            chk("bounds_expected", {31'h0, exp_bounds > 0}, 32'd1);
            if (exp_bounds > 0) exp_bounds--;
        end
`endif
    end

    // Issue one request, holding it while stall is high. bad=1 means the request must be dropped.
    task automatic issue(input mem_op_e op, input logic [31:0] a, input logic [31:0] sd,
                         input bit bad);
        int  n;
        bit  s;
        bit  sub;
        n = 0;
        sub = (op == SB) || (op == SH);
        @(posedge clk); #1;
        req_valid = 1'b1; mem_op = op; addr = a; store_data = sd;
        @(negedge clk);
        if (bad) chk("drop_strobes", {29'h0, stall, MemRead, MemWrite}, 32'h0);
        else if (sub) chk("rmw_read", {29'h0, stall, MemRead, MemWrite}, 32'h6);
        else if (is_store(op)) chk("sw_write", {29'h0, stall, MemRead, MemWrite}, 32'h1);
        else chk("load_read", {29'h0, stall, MemRead, MemWrite}, 32'h2);
        s = stall;
        @(posedge clk); #1;
        while (s && n < 4) begin
            @(negedge clk); s = stall;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 4) chk("stall_bound", 32'd1, 32'd0);
        req_valid = 1'b0;
    endtask

    task automatic ld(input mem_op_e op, input logic [31:0] a, input logic [31:0] e);
        exp_load.push_back(e);
        issue(op, a, 32'h0, 1'b0);
    endtask

    task automatic st(input mem_op_e op, input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] e);
        wr_t w;
        w.idx = a[17:2];
        w.data = e;
        exp_wr.push_back(w);
        issue(op, a, sd, 1'b0);
    endtask

    task automatic bad(input mem_op_e op, input logic [31:0] a);
        exp_misal++;
        issue(op, a, 32'hFFFF_FFFF, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[0] = 32'h8899AABB;
        mem[1] = 32'h11223344;
        mem[2] = 32'hCAFEF00D;

        // Reset: strobes forced low even with a request present.
        req_valid = 1'b1; mem_op = SB; addr = 32'h1;
        @(posedge clk); @(negedge clk);
        chk("rst_strobes", {29'h0, stall, MemRead, MemWrite}, 32'h0);
        chk("rst_pulses", {30'h0, load_valid, misalign}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;

        // Sub-word and word loads.
        ld(LB,  32'h3, 32'hFFFFFF88);
        ld(LBU, 32'h3, 32'h00000088);
        ld(LH,  32'h0, 32'hFFFFAABB);
        ld(LHU, 32'h2, 32'h00008899);
        ld(LB,  32'h0, 32'hFFFFFFBB);
        ld(LBU, 32'h1, 32'h000000AA);
        ld(LH,  32'h2, 32'hFFFF8899);
        ld(LW,  32'h0, 32'h8899AABB);

        // Read-modify-write stores and readback.
        st(SB, 32'h5, 32'h123456CC, 32'h1122CC44);
        ld(LW, 32'h4, 32'h1122CC44);
        st(SH, 32'h8, 32'h0000BEEF, 32'hCAFEBEEF);
        st(SB, 32'hA, 32'h00000077, 32'hCA77BEEF);
        ld(LW, 32'h8, 32'hCA77BEEF);
        st(SW, 32'hC, 32'hDEADBEEF, 32'hDEADBEEF);
        ld(LW, 32'hC, 32'hDEADBEEF);

        // Misaligned accesses are dropped.
        bad(SW, 32'h6);
        ld(LW, 32'h4, 32'h1122CC44);
        bad(LH, 32'h1);
        bad(LW, 32'h3);
        bad(SH, 32'h3);
        ld(LW, 32'h0, 32'h8899AABB);

        // Reset during the write-back cycle of a halfword store.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_op = SH; addr = 32'h2; store_data = 32'h0000BEEF;
        @(negedge clk);
        chk("rstwr_read", {29'h0, stall, MemRead, MemWrite}, 32'h6);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_strobes", {29'h0, stall, MemRead, MemWrite}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rstwr_idle", {29'h0, stall, MemRead, MemWrite}, 32'h0);
        chk("rstwr_pulses", {30'h0, load_valid, misalign}, 32'h0);
        chk("rstwr_load_data", load_data, 32'h0);
        ld(LW, 32'h0, 32'h8899AABB);

        // Out-of-range address.
`ifdef LSU_BOUNDS_CHECK_EN
        exp_bounds++;
        issue(LW, 32'h00040000, 32'h0, 1'b1);
`else
        ld(LW, 32'h00040004, 32'h1122CC44);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("load_queue_empty", exp_load.size(), 32'd0);
        chk("write_queue_empty", exp_wr.size(), 32'd0);
        chk("misalign_pending", exp_misal, 32'd0);
        chk("bounds_pending", exp_bounds, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit sitting directly upstream of the word-addressed data memory; drives its MemRead/MemWrite/Address/WD and consumes RD.
- Adds byte/halfword loads (sign/zero-extended) and byte/halfword stores via read-modify-write, since the memory has no byte enables.
- Detects misaligned accesses.
- Registers load results toward the writeback stage.

Parameters:
- WIDTH, 32, data/address width.
- DEPTHI, 16, log2 of memory depth in words; must match the data memory instance.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  memory-stage request present
- mem_op  input  3  operation code (package enum)
- addr  input  WIDTH  byte address from ALU
- store_data  input  WIDTH  rt value for stores
- stall  output  1  pipeline must hold inputs stable
- load_data  output  WIDTH  extended load result, registered
- load_valid  output  1  load_data valid (1-cycle pulse)
- misalign  output  1  misaligned access flagged (1-cycle pulse)
- MemRead  output  1  to memory read enable
- MemWrite  output  1  to memory write enable
- Address  output  WIDTH  word index = {2'b00, addr[WIDTH-1:2]}
- WD  output  WIDTH  write data to memory
- RD  input  WIDTH  read data from memory; updated at negedge clk when MemRead=1

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high on clk/rst.
  - On rst: state=S_IDLE; load_data=0, load_valid=0, misalign=0, merge buffer=0.
  - While rst is high, stall/MemRead/MemWrite are forced 0.
- Byte order: little-endian lanes. addr[1:0]=0 selects bits 7:0. addr[1]=0 selects halfword 15:0.
- Alignment:
  - LH/LHU/SH misaligned when addr[0]=1.
  - LW/SW misaligned when addr[1:0]!=0.
  - LB/LBU/SB are always aligned.
  - On a misaligned request: no MemRead/MemWrite, stall=0, misalign=1 on the next cycle, load_valid stays 0.
- States: S_IDLE, S_WR.
- S_IDLE, no req_valid: all memory strobes 0, stall=0.
- S_IDLE, load (LB/LH/LW/LBU/LHU):
  - MemRead=1, stall=0.
  - At posedge: load_data <= lane of RD, extended (LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough); load_valid <= 1.
  - Latency 1 cycle.
- S_IDLE, SW: MemWrite=1, WD=store_data, stall=0. Single cycle.
- S_IDLE, SB/SH:
  - MemRead=1, stall=1.
  - At posedge: merge buffer <= RD with the addressed lane replaced by store_data[7:0] / [15:0].
  - Next state S_WR.
- S_WR: MemWrite=1, WD=merge buffer, Address from the held addr, stall=0; then S_IDLE. Sub-word store costs 2 cycles.
- Pulse outputs: load_valid and misalign are high exactly one cycle per qualifying request, otherwise 0.
- MemRead and MemWrite are never both 1 in the same cycle.
- Reset asserted in S_WR: the write is suppressed, state returns to S_IDLE.
- Address range: upper address bits beyond DEPTHI+2 are ignored; the memory wraps modulo 2^DEPTHI words.
- mem_op is ignored when req_valid=0.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined:
  - A request with addr[WIDTH-1:DEPTHI+2] != 0 is treated as a fault: no memory access, stall=0.
  - Output port bounds_err (1 bit) pulses 1 the next cycle.
  - misalign takes priority when both conditions hold.
- Undefined: port absent; out-of-range addresses wrap as described.

Decomposition:
- Package mips_mem_pkg holds:
  - mem_op_e: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
  - lsu_state_e {S_IDLE, S_WR}.
  - Helpers is_store(op) and op_size(op).
- One natural sub-module: lsu_lane_align. Combinational; performs lane extract/extend for loads and lane merge for stores.

Test Plan:
- Memory word0=0x8899AABB. LB addr=0x3 -> next cycle load_valid=1, load_data=0xFFFFFF88. LBU addr=0x3 -> 0x00000088.
- LH addr=0x0 on word0 -> 0xFFFFAABB. LHU addr=0x2 -> 0x00008899.
- SB addr=0x5, store_data=0x123456CC, word1=0x11223344:
  - stall=1 for one cycle with MemRead=1.
  - Next cycle MemWrite=1, WD=0x1122CC44.
  - Readback LW addr=0x4 -> 0x1122CC44.
- SW addr=0x6 -> no MemWrite, misalign=1 next cycle, memory unchanged. LH addr=0x1 -> misalign=1, load_valid=0.
- SH addr=0x2, store_data=0xBEEF: assert rst during S_WR -> no MemWrite, outputs zero, state S_IDLE; subsequent LW returns the pre-store value.
- With LSU_BOUNDS_CHECK_EN, DEPTHI=16: LW addr=0x00040000 -> bounds_err=1 next cycle, no MemRead.
